// File: rtl/acc_quant_pkg.sv
// Shared constants and arithmetic helpers for the acc_quant requantisation stage.
package acc_quant_pkg;
  localparam int D_W     = 8;
  localparam int D_W_ACC = 32;
  localparam int PROD_W  = 2 * D_W_ACC;
  localparam int E_MAX   = 63;

  function automatic logic signed [D_W_ACC-1:0] sat32(input logic [D_W_ACC:0] x);
    if (x[D_W_ACC] != x[D_W_ACC-1])
      return x[D_W_ACC] ? {1'b1, {(D_W_ACC-1){1'b0}}} : {1'b0, {(D_W_ACC-1){1'b1}}};
    return x[D_W_ACC-1:0];
  endfunction

  function automatic logic [D_W-1:0] sat_n(input logic [PROD_W:0] x);
    if (&x[PROD_W:D_W-1] || ~|x[PROD_W:D_W-1])
      return x[D_W-1:0];
    return x[PROD_W] ? {1'b1, {(D_W-1){1'b0}}} : {1'b0, {(D_W-1){1'b1}}};
  endfunction

  // One guard bit above the product so the half-LSB add cannot wrap.
  function automatic logic signed [PROD_W:0] round_shift(input logic signed [PROD_W-1:0] p,
                                                         input logic [5:0] e);
    logic signed [PROD_W:0] t;
    t = {p[PROD_W-1], p};
    if (e != 6'd0)
      t = t + ((PROD_W+1)'(1) << (e - 6'd1));
    return t >>> e;
  endfunction
endpackage

// File: rtl/acc_quant_if.sv
// Input lanes from the bias/M/E buffer plus the AXI-stream result port.
interface acc_quant_if;
  import acc_quant_pkg::*;

  logic signed [D_W_ACC-1:0] acc_data;
  logic                      acc_valid;
  logic signed [D_W_ACC-1:0] bias_data;
  logic                      bias_valid;
  logic                      bias_last;
  logic signed [D_W_ACC-1:0] M_data;
  logic                      M_valid;
  logic                      M_last;
  logic [D_W-1:0]            E_data;
  logic                      E_valid;
  logic                      E_last;
  logic                      back_ready;
  logic signed [D_W-1:0]     m_axis_tdata;
  logic                      m_axis_tvalid;
  logic                      m_axis_tready;
  logic                      m_axis_tlast;

  modport slave (
    input  acc_data, acc_valid, bias_data, bias_valid, bias_last,
           M_data, M_valid, M_last, E_data, E_valid, E_last, m_axis_tready,
    output back_ready, m_axis_tdata, m_axis_tvalid, m_axis_tlast
  );

  modport master (
    output acc_data, acc_valid, bias_data, bias_valid, bias_last,
           M_data, M_valid, M_last, E_data, E_valid, E_last, m_axis_tready,
    input  back_ready, m_axis_tdata, m_axis_tvalid, m_axis_tlast
  );
endinterface

// File: rtl/acc_quant_sync_fifo.sv
// Show-ahead synchronous FIFO with occupancy count; a push into a full FIFO without a pop is dropped.
module sync_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     drop
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             full, do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign drop    = push & full & ~do_pop;
  assign rdata   = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end
endmodule

// File: rtl/acc_quant.sv
// Requantiser: int8 = sat8(round((sat32(acc+bias) * M) >>> E)), 4-stage pipeline,
// output FIFO on AXI-stream and a registered credit back to the skewed upstream buffer.
module acc_quant
  import acc_quant_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int SLACK      = 8
) (
  input  logic         clk,
  input  logic         rst,
  acc_quant_if.slave   bus,
  output logic         frame_done,
  output logic         err_align,
  output logic         err_ovf
);
  localparam int CW = $clog2(FIFO_DEPTH) + 2;

  logic                      v0, v1, v2;
  logic                      last0, last1, last2;
  logic signed [D_W_ACC-1:0] s0;
  logic signed [PROD_W-1:0]  p1;
  logic signed [PROD_W:0]    r2;
  logic [5:0]                e_clamped;
  logic                      align_bad;
  logic [D_W:0]              fifo_wdata, fifo_rdata;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic                      fifo_empty, fifo_drop, pop;
  logic [CW-1:0]             inflight;

  assign e_clamped = (bus.E_data > D_W'(E_MAX)) ? 6'(E_MAX) : bus.E_data[5:0];

  // M and E lanes trail the bias lane by one and two cycles respectively.
  assign align_bad = (bus.acc_valid != bus.bias_valid)
                   | (bus.M_valid != v0) | (v0 & (bus.M_last != last0))
                   | (bus.E_valid != v1) | (v1 & (bus.E_last != last1));

  always_ff @(posedge clk) begin
    if (rst) begin
      v0             <= 1'b0;
      v1             <= 1'b0;
      v2             <= 1'b0;
      err_align      <= 1'b0;
      err_ovf        <= 1'b0;
      bus.back_ready <= 1'b0;
    end else begin
      v0             <= bus.bias_valid;
      v1             <= v0;
      v2             <= v1;
      err_align      <= err_align | align_bad;
      err_ovf        <= err_ovf | fifo_drop;
      bus.back_ready <= (inflight <= CW'(FIFO_DEPTH - SLACK));
    end
  end

  always_ff @(posedge clk) begin
    last0 <= bus.bias_last;
    s0    <= sat32({bus.acc_data[D_W_ACC-1], bus.acc_data} + {bus.bias_data[D_W_ACC-1], bus.bias_data});
    last1 <= last0;
    p1    <= PROD_W'(s0) * PROD_W'(bus.M_data);
    last2 <= last1;
    r2    <= round_shift(p1, e_clamped);
  end

  assign fifo_wdata = {last2, sat_n(r2)};
  assign pop        = ~fifo_empty & bus.m_axis_tready;

  sync_fifo #(
    .WIDTH (D_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (v2),
    .wdata (fifo_wdata),
    .pop   (pop),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .empty (fifo_empty),
    .drop  (fifo_drop)
  );

  assign inflight = CW'(fifo_count) + CW'(v0) + CW'(v1) + CW'(v2);

  assign bus.m_axis_tvalid = ~fifo_empty;
  assign bus.m_axis_tdata  = fifo_rdata[D_W-1:0];
  assign bus.m_axis_tlast  = fifo_rdata[D_W];
  assign frame_done        = pop & fifo_rdata[D_W];
endmodule

// File: tb/tb_acc_quant.sv
// Directed bench for acc_quant: drives correctly skewed lanes and checks against hand-computed results.
module tb_acc_quant;
  import acc_quant_pkg::*;

  typedef struct packed {
    logic        v;
    logic        last;
    logic [31:0] acc;
    logic [31:0] bias;
    logic [31:0] m;
    logic [7:0]  e;
  } elem_t;

  logic clk = 1'b0;
  logic rst;
  logic frame_done, err_align, err_ovf;

  always #5 clk = ~clk;

  acc_quant_if bus();

  acc_quant #(.FIFO_DEPTH(16), .SLACK(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus.slave),
    .frame_done (frame_done),
    .err_align  (err_align),
    .err_ovf    (err_ovf)
  );

  elem_t l0, l1, l2, l3;
  bit    m_skew;
  int    n_cmp = 0;
  int    n_bad = 0;
  int    n_fd  = 0;
  int    issued;
  logic [8:0] rx[$];

  task automatic check(input string tag, input longint got, input longint exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.m_axis_tvalid && bus.m_axis_tready)
        rx.push_back({bus.m_axis_tlast, bus.m_axis_tdata});
      if (frame_done) n_fd++;
    end
  end

  function automatic elem_t mk(input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] m, input logic [7:0] e, input logic last);
    elem_t x;
    x.v = 1'b1; x.last = last; x.acc = a; x.bias = b; x.m = m; x.e = e;
    return x;
  endfunction

  function automatic longint res(input int i);
    if (i < rx.size()) return longint'($signed(rx[i][7:0]));
    return -999;
  endfunction

  task automatic drive();
    elem_t mm;
    mm = m_skew ? l3 : l1;
    bus.acc_valid  = l0.v;
    bus.acc_data   = l0.acc;
    bus.bias_valid = l0.v;
    bus.bias_data  = l0.bias;
    bus.bias_last  = l0.last;
    bus.M_valid    = mm.v;
    bus.M_data     = mm.m;
    bus.M_last     = mm.last;
    bus.E_valid    = l2.v;
    bus.E_data     = l2.e;
    bus.E_last     = l2.last;
  endtask

  task automatic step(input elem_t nx);
    l3 = l2; l2 = l1; l1 = l0; l0 = nx;
    drive();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step('0);
  endtask

  task automatic single(input string tag, input elem_t x, input longint exp);
    rx.delete();
    step(x);
    idle(7);
    check({tag, "_cnt"}, rx.size(), 1);
    check(tag, res(0), exp);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation bound expired");
    $fatal(1, "timeout");
  end

  initial begin
    int bad;
    int lasts;
    rst = 1'b1;
    bus.m_axis_tready = 1'b1;
    l0 = '0; l1 = '0; l2 = '0; l3 = '0;
    m_skew = 1'b0;
    drive();
    repeat (3) @(posedge clk);
    #1;
    check("rst_tvalid", bus.m_axis_tvalid, 0);
    check("rst_tdata", bus.m_axis_tdata, 0);
    check("rst_tlast", bus.m_axis_tlast, 0);
    check("rst_back_ready", bus.back_ready, 0);
    check("rst_err_align", err_align, 0);
    check("rst_err_ovf", err_ovf, 0);
    check("rst_frame_done", frame_done, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("rst_br_rise", bus.back_ready, 1);

    // (100+28)*3 = 384, (384+2)>>>2 = 96; visible after the fourth edge
    rx.delete();
    step(mk(32'd100, 32'd28, 32'd3, 8'd2, 1'b0));
    step('0);
    step('0);
    check("lat_early_tvalid", bus.m_axis_tvalid, 0);
    step('0);
    check("lat_tvalid", bus.m_axis_tvalid, 1);
    check("lat_tdata", longint'(bus.m_axis_tdata), 96);
    idle(4);
    check("lat_cnt", rx.size(), 1);

    single("sat_pos", mk(32'd1000, 32'd0, 32'd1, 8'd0, 1'b0), 127);
    single("sat_neg", mk(-32'sd1000, 32'd0, 32'd1, 8'd0, 1'b0), -128);
    single("sat32", mk(32'h7FFF_FFFF, 32'd1, 32'd1, 8'd24, 1'b0), 127);
    single("rnd_neg", mk(-32'sd5, 32'd0, 32'd1, 8'd1, 1'b0), -2);
    single("rnd_pos", mk(32'd5, 32'd0, 32'd1, 8'd1, 1'b0), 3);
    single("rnd_e0", mk(32'd7, 32'd0, 32'd1, 8'd0, 1'b0), 7);
    single("e_clamp", mk(32'h7FFF_FFFF, 32'd0, 32'h7FFF_FFFF, 8'd200, 1'b0), 0);
    check("dir_err_align", err_align, 0);
    check("dir_err_ovf", err_ovf, 0);

    // backpressure: issue gated by back_ready with the sink stalled
    rx.delete();
    n_fd = 0;
    issued = 0;
    bus.m_axis_tready = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (bus.back_ready && issued < 64) begin
        step(mk(32'(issued), 32'd0, 32'd1, 8'd0, issued == 63));
        issued++;
      end else begin
        step('0);
      end
    end
    check("bp_issued_stall", issued, 10);
    check("bp_br_low", bus.back_ready, 0);
    check("bp_tvalid", bus.m_axis_tvalid, 1);
    check("bp_no_out", rx.size(), 0);
    check("bp_ovf_stall", err_ovf, 0);
    bus.m_axis_tready = 1'b1;
    for (int c = 0; c < 600 && issued < 64; c++) begin
      if (bus.back_ready) begin
        step(mk(32'(issued), 32'd0, 32'd1, 8'd0, issued == 63));
        issued++;
      end else begin
        step('0);
      end
    end
    idle(20);
    check("bp_issued", issued, 64);
    check("bp_cnt", rx.size(), 64);
    bad = 0;
    lasts = 0;
    for (int i = 0; i < rx.size(); i++) begin
      if (rx[i][7:0] != 8'(i)) bad++;
      if (rx[i][8]) lasts++;
    end
    check("bp_order", bad, 0);
    check("bp_last_cnt", lasts, 1);
    check("bp_last_pos", (rx.size() == 64) ? longint'(rx[63][8]) : 0, 1);
    check("bp_frame_done", n_fd, 1);
    check("bp_err_ovf", err_ovf, 0);
    check("bp_err_align", err_align, 0);

    // M lane two cycles late
    rx.delete();
    m_skew = 1'b1;
    step(mk(32'd10, 32'd0, 32'd1, 8'd0, 1'b0));
    idle(8);
    m_skew = 1'b0;
    check("skew_err", err_align, 1);
    check("skew_cnt", rx.size(), 1);
    idle(10);
    check("skew_sticky", err_align, 1);

    // reset with 3 elements in flight and 5 queued
    rx.delete();
    bus.m_axis_tready = 1'b0;
    for (int i = 0; i < 8; i++) step(mk(32'(20 + i), 32'd0, 32'd1, 8'd0, 1'b0));
    check("mid_tvalid", bus.m_axis_tvalid, 1);
    rst = 1'b1;
    l0 = '0; l1 = '0; l2 = '0; l3 = '0;
    drive();
    @(posedge clk);
    #1;
    check("mid_rst_tvalid", bus.m_axis_tvalid, 0);
    check("mid_rst_br", bus.back_ready, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("mid_br_rise", bus.back_ready, 1);
    check("mid_err_clear", err_align, 0);
    bus.m_axis_tready = 1'b1;
    idle(10);
    check("mid_no_stale", rx.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
